// File: rtl/stub_layer_router_buf.sv
// stub_layer_router_buf: routes input-link stubs into per-layer, BX-paged
// stub memories. Each stub's layer field selects the destination memory.
// The block exposes per-layer/per-page stub counts, a registered
// random-access read port, and overflow / dropped-stub monitoring.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | not accepting stubs; waits for start & en_proc
// S_ACTIVE | accepting stubs into wr_page; start flips to the next page
module stub_layer_router_buf #(
  parameter int NLAYER     = 6,
  parameter int STUB_W     = 36,
  parameter int LAYER_LSB  = 33,
  parameter int DEPTH_LOG2 = 6,
  parameter int NPAGE_LOG2 = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en_proc,
  input  logic                  i_start,
  input  logic [STUB_W-1:0]     i_stub_in,
  input  logic                  i_stub_valid,
  output logic                  o_stub_ready,
  input  logic [2:0]            i_rd_layer,
  input  logic [NPAGE_LOG2-1:0] i_rd_page,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [STUB_W-1:0]     o_rd_data,
  output logic [DEPTH_LOG2:0]   o_rd_number,
  output logic [NPAGE_LOG2-1:0] o_wr_page,
  output logic                  o_done,
  output logic [NLAYER-1:0]     o_ovf_flags,
  output logic [15:0]           o_drop_cnt,
  input  logic                  i_ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NPAGE = 1 << NPAGE_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_stub_ready;
  logic                    w_page_open;
  logic                    w_page_flip;

  logic [NPAGE_LOG2-1:0]   r_wr_page;
  logic [NPAGE_LOG2-1:0]   w_new_page;
  logic                    r_done;

  logic [CNT_W-1:0]        r_count [NLAYER][NPAGE];
  logic [STUB_W-1:0]       r_mem   [NLAYER][NPAGE][DEPTH];

  logic [2:0]              w_layer;
  logic [2:0]              w_lidx;
  logic                    w_layer_ok;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_cur_cnt;
  logic                    w_full;
  logic                    w_wr_en;
  logic                    w_ovf;
  logic                    w_drop;

  logic [NLAYER-1:0]       r_ovf_flags;
  logic [NLAYER-1:0]       w_ovf_nxt;
  logic [15:0]             r_drop_cnt;
  logic [15:0]             w_drop_base;
  logic [15:0]             w_drop_nxt;

  logic [STUB_W-1:0]       r_rd_data;
  logic [CNT_W-1:0]        r_rd_number;
  logic [STUB_W-1:0]       w_rd_data;
  logic [CNT_W-1:0]        w_rd_cnt;

  // Next-state and control decode for the sequencing FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_stub_ready = 1'b0;
    w_page_open  = 1'b0;
    w_page_flip  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && i_en_proc) begin
          w_state_nxt = S_ACTIVE;
          w_page_open = 1'b1;
        end
      end
      S_ACTIVE: begin
        w_stub_ready = 1'b1;
        if (i_start) w_page_flip = 1'b1;
        if (!i_en_proc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_new_page = r_wr_page + NPAGE_LOG2'(1);

  // State register, write page pointer and page-closed pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_wr_page <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_page_flip;
      if (w_page_flip) r_wr_page <= w_new_page;
    end
  end

  // Layer decode; layer field value L maps to memory index L-1.
  assign w_layer    = i_stub_in[LAYER_LSB +: 3];
  assign w_lidx     = w_layer - 3'd1;
  assign w_layer_ok = (w_layer != 3'd0) && (w_layer <= 3'(NLAYER));
  assign w_accept   = i_stub_valid && w_stub_ready;

  // Live count of the destination layer in the page being written.
  always_comb begin
    w_cur_cnt = '0;
    for (int l = 0; l < NLAYER; l++) begin
      if (w_lidx == 3'(l)) w_cur_cnt = r_count[l][r_wr_page];
    end
  end

  assign w_full  = (w_cur_cnt == CNT_FULL);
  assign w_wr_en = w_accept && w_layer_ok && !w_full;
  assign w_ovf   = w_accept && w_layer_ok && w_full;
  assign w_drop  = w_accept && (!w_layer_ok || w_full);

  // Per-layer/per-page counts: cleared when a page is (re)opened, bumped on write.
  // An accept coincident with a flip targets the old page, which is never
  // the page being cleared because there are at least two pages.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int l = 0; l < NLAYER; l++) begin
        for (int p = 0; p < NPAGE; p++) begin
          r_count[l][p] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < NLAYER; l++) begin
        for (int p = 0; p < NPAGE; p++) begin
          if ((w_page_open && (NPAGE_LOG2'(p) == r_wr_page)) ||
              (w_page_flip && (NPAGE_LOG2'(p) == w_new_page))) begin
            r_count[l][p] <= '0;
          end else if (w_wr_en && (w_lidx == 3'(l)) &&
                       (NPAGE_LOG2'(p) == r_wr_page)) begin
            r_count[l][p] <= r_count[l][p] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Stub storage; contents survive reset, only the counts are cleared.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_wr_en) begin
      for (int l = 0; l < NLAYER; l++) begin
        if (w_lidx == 3'(l)) begin
          r_mem[l][r_wr_page][w_cur_cnt[DEPTH_LOG2-1:0]] <= i_stub_in;
        end
      end
    end
  end

  // Overflow flag / drop counter next values; a same-cycle event beats the clear.
  always_comb begin
    w_ovf_nxt = i_ovf_clr ? '0 : r_ovf_flags;
    for (int l = 0; l < NLAYER; l++) begin
      if (w_ovf && (w_lidx == 3'(l))) w_ovf_nxt[l] = 1'b1;
    end
    w_drop_base = i_ovf_clr ? 16'h0000 : r_drop_cnt;
    w_drop_nxt  = w_drop_base;
    if (w_drop && (w_drop_base != 16'hFFFF)) w_drop_nxt = w_drop_base + 16'd1;
  end

  // Sticky overflow flags and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ovf_flags <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_ovf_flags <= w_ovf_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  // Read mux; an out-of-range layer selects nothing and yields zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_cnt  = '0;
    for (int l = 0; l < NLAYER; l++) begin
      if (i_rd_layer == 3'(l)) begin
        w_rd_data = r_mem[l][i_rd_page][i_rd_addr];
        w_rd_cnt  = r_count[l][i_rd_page];
      end
    end
  end

  // Registered read port; sampling pre-edge state gives read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rd_data   <= '0;
      r_rd_number <= '0;
    end else begin
      r_rd_data   <= w_rd_data;
      r_rd_number <= w_rd_cnt;
    end
  end

  assign o_stub_ready = w_stub_ready;
  assign o_rd_data    = r_rd_data;
  assign o_rd_number  = r_rd_number;
  assign o_wr_page    = r_wr_page;
  assign o_done       = r_done;
  assign o_ovf_flags  = r_ovf_flags;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_stub_layer_router_buf.sv
// Directed bench for stub_layer_router_buf with default parameters.
module tb_stub_layer_router_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_proc = 1'b0;
  logic        start = 1'b0;
  logic [35:0] stub_in = '0;
  logic        stub_valid = 1'b0;
  logic        stub_ready;
  logic [2:0]  rd_layer = '0;
  logic [0:0]  rd_page = '0;
  logic [5:0]  rd_addr = '0;
  logic [35:0] rd_data;
  logic [6:0]  rd_number;
  logic [0:0]  wr_page;
  logic        done;
  logic [5:0]  ovf_flags;
  logic [15:0] drop_cnt;
  logic        ovf_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stub_layer_router_buf dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_en_proc    (en_proc),
    .i_start      (start),
    .i_stub_in    (stub_in),
    .i_stub_valid (stub_valid),
    .o_stub_ready (stub_ready),
    .i_rd_layer   (rd_layer),
    .i_rd_page    (rd_page),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_number  (rd_number),
    .o_wr_page    (wr_page),
    .o_done       (done),
    .o_ovf_flags  (ovf_flags),
    .o_drop_cnt   (drop_cnt),
    .i_ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk(input logic [2:0] l, input logic [32:0] v);
    return {l, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [35:0] s);
    stub_in    = s;
    stub_valid = 1'b1;
    tick();
    stub_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] l, input logic p, input logic [5:0] a);
    rd_layer = l;
    rd_page  = p;
    rd_addr  = a;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_ready", stub_ready, 0);
    chk("rst_wr_page", wr_page, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_number", rd_number, 0);
    chk("rst_ovf", ovf_flags, 0);
    chk("rst_drop", drop_cnt, 0);

    // enter ACTIVE
    rst_n   = 1'b1;
    en_proc = 1'b1;
    tick();
    chk("idle_ready", stub_ready, 0);
    pulse_start();
    chk("active_ready", stub_ready, 1);
    chk("active_done", done, 0);

    // accept / route
    send(mk(3'd2, 33'h100000001));
    send(mk(3'd2, 33'h100000002));
    send(mk(3'd2, 33'h100000003));
    send(mk(3'd5, 33'h100000004));
    pulse_start();
    chk("flip_done", done, 1);
    chk("flip_wr_page", wr_page, 1);
    tick();
    chk("done_one_cycle", done, 0);
    rd(3'd1, 1'b0, 6'd0);
    chk("l1p0_number", rd_number, 3);
    chk("l1p0_a0", rd_data, mk(3'd2, 33'h100000001));
    rd(3'd1, 1'b0, 6'd1);
    chk("l1p0_a1", rd_data, mk(3'd2, 33'h100000002));
    rd(3'd1, 1'b0, 6'd2);
    chk("l1p0_a2", rd_data, mk(3'd2, 33'h100000003));
    rd(3'd4, 1'b0, 6'd0);
    chk("l4p0_number", rd_number, 1);
    chk("l4p0_a0", rd_data, mk(3'd5, 33'h100000004));
    rd(3'd0, 1'b0, 6'd0);
    chk("l0p0_number", rd_number, 0);

    // overflow: 65 stubs to layer 1 in page 1
    for (int i = 0; i < 65; i++) send(mk(3'd1, 33'h200 + 33'(i)));
    rd(3'd0, 1'b1, 6'd63);
    chk("ovf_number", rd_number, 64);
    chk("ovf_a63", rd_data, mk(3'd1, 33'h23F));
    chk("ovf_flags", ovf_flags, 6'b000001);
    chk("ovf_drop", drop_cnt, 1);
    rd(3'd0, 1'b1, 6'd0);
    chk("ovf_a0", rd_data, mk(3'd1, 33'h200));

    // ovf_clr alone
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_flags", ovf_flags, 0);
    chk("clr_drop", drop_cnt, 0);

    // bad layers
    send(mk(3'd0, 33'h700));
    send(mk(3'd7, 33'h701));
    chk("bad_drop", drop_cnt, 2);
    chk("bad_flags", ovf_flags, 0);
    rd(3'd0, 1'b1, 6'd0);
    chk("bad_l0p1_number", rd_number, 64);
    rd(3'd1, 1'b0, 6'd0);
    chk("bad_l1p0_number", rd_number, 3);
    rd(3'd4, 1'b0, 6'd0);
    chk("bad_l4p0_number", rd_number, 1);
    rd(3'd6, 1'b0, 6'd0);
    chk("oor6_data", rd_data, 0);
    chk("oor6_number", rd_number, 0);
    rd(3'd7, 1'b1, 6'd3);
    chk("oor7_data", rd_data, 0);
    chk("oor7_number", rd_number, 0);

    // page wrap: 0,1,0 with one stub per page on layer 6
    pulse_start();
    chk("wrap_page_a", wr_page, 0);
    send(mk(3'd6, 33'h300));
    pulse_start();
    chk("wrap_page_b", wr_page, 1);
    send(mk(3'd6, 33'h301));
    pulse_start();
    chk("wrap_page_c", wr_page, 0);
    rd(3'd5, 1'b0, 6'd0);
    chk("wrap_p0_cleared", rd_number, 0);
    rd(3'd5, 1'b1, 6'd0);
    chk("wrap_p1_kept", rd_number, 1);
    chk("wrap_p1_data", rd_data, mk(3'd6, 33'h301));
    send(mk(3'd6, 33'h302));
    rd(3'd5, 1'b0, 6'd0);
    chk("wrap_p0_number", rd_number, 1);
    chk("wrap_p0_data", rd_data, mk(3'd6, 33'h302));

    // start coincident with an accepted layer-3 stub
    stub_in    = mk(3'd3, 33'h400);
    stub_valid = 1'b1;
    start      = 1'b1;
    tick();
    stub_valid = 1'b0;
    start      = 1'b0;
    chk("sim_wr_page", wr_page, 1);
    chk("sim_done", done, 1);
    rd(3'd2, 1'b0, 6'd0);
    chk("sim_old_number", rd_number, 1);
    chk("sim_old_data", rd_data, mk(3'd3, 33'h400));
    rd(3'd2, 1'b1, 6'd0);
    chk("sim_new_number", rd_number, 0);

    // ovf_clr together with an overflow
    for (int i = 0; i < 64; i++) send(mk(3'd1, 33'h500 + 33'(i)));
    rd(3'd0, 1'b1, 6'd0);
    chk("fill_number", rd_number, 64);
    chk("pre_clr_drop", drop_cnt, 2);
    stub_in    = mk(3'd1, 33'h5FF);
    stub_valid = 1'b1;
    ovf_clr    = 1'b1;
    tick();
    stub_valid = 1'b0;
    ovf_clr    = 1'b0;
    chk("clrovf_flags", ovf_flags, 6'b000001);
    chk("clrovf_drop", drop_cnt, 1);

    // read-first on the page being written
    pulse_start();
    chk("rf_wr_page", wr_page, 0);
    rd_layer   = 3'd1;
    rd_page    = 1'b0;
    rd_addr    = 6'd0;
    stub_in    = mk(3'd2, 33'h600);
    stub_valid = 1'b1;
    tick();
    stub_valid = 1'b0;
    chk("rf_old_data", rd_data, mk(3'd2, 33'h100000001));
    chk("rf_old_number", rd_number, 0);
    tick();
    chk("rf_new_data", rd_data, mk(3'd2, 33'h600));
    chk("rf_new_number", rd_number, 1);

    // reset mid-operation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_ready", stub_ready, 0);
    chk("mrst_wr_page", wr_page, 0);
    chk("mrst_flags", ovf_flags, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_rd_data", rd_data, 0);
    chk("mrst_rd_number", rd_number, 0);
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < 2; p++) begin
        rd(3'(l), 1'(p), 6'd0);
        chk("mrst_count", rd_number, 0);
      end
    end
    send(mk(3'd1, 33'h800));
    chk("mrst_idle_ready", stub_ready, 0);
    rd(3'd0, 1'b0, 6'd0);
    chk("mrst_idle_nowrite", rd_number, 0);
    pulse_start();
    chk("mrst_restart_ready", stub_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
